// File: rtl/inst_issuer.sv
// Instruction issuer: buffers a small program written one entry at a time and
// replays it in order over a valid/ready handshake, once or looping.
module inst_issuer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ena,
   input  logic          clear,
   input  logic          wr_en,
   input  logic [2:0]    wr_opcode,
   input  logic [3:0]    wr_operand,
   input  logic          start,
   input  logic          loop,
   input  logic          stop,
   output logic [7:0]    instr_out,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [AW-1:0] pc,
   output logic [AW:0]   prog_len,
   output logic          busy,
   output logic          done,
   output logic          overflow
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

   state_t        state;
   logic [7:0]    prog_mem [DEPTH];
   logic          xfer;
   logic          at_last;
   logic          full;
   logic          do_write;
   logic          do_load;
   logic [AW-1:0] rd_addr;

   always_comb begin
      xfer     = ena & instr_valid & instr_ready;
      at_last  = ({1'b0, pc} == (prog_len - 1'b1));
      full     = (prog_len == FULL_LEN);
      do_write = ena & (state != RUN) & !stop & !start & !clear & wr_en & !full;
      do_load  = 1'b0;
      rd_addr  = '0;
      // Next entry to place on instr_out: entry 0 on start or wrap, else pc+1.
      if (ena && !stop) begin
         if (state != RUN) begin
            do_load = start & (prog_len != '0);
         end else if (xfer) begin
            do_load = !at_last | loop;
            rd_addr = at_last ? '0 : pc + 1'b1;
         end
      end
   end

   // Program storage is deliberately not reset.
   always_ff @(posedge clock) begin
      if (do_write)
         prog_mem[prog_len[AW-1:0]] <= {wr_opcode, 1'b0, wr_operand};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         prog_len    <= '0;
         pc          <= '0;
         instr_out   <= 8'h00;
         instr_valid <= 1'b0;
         overflow    <= 1'b0;
      end else if (ena) begin
         if (do_load)
            instr_out <= prog_mem[rd_addr];
         if (stop) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            pc          <= '0;
         end else begin
            case (state)
               RUN: begin
                  if (xfer) begin
                     if (!at_last) begin
                        pc <= pc + 1'b1;
                     end else if (loop) begin
                        pc <= '0;
                     end else begin
                        state       <= DONE;
                        instr_valid <= 1'b0;
                     end
                  end
               end
               default: begin
                  if (start) begin
                     if (prog_len != '0) begin
                        state       <= RUN;
                        pc          <= '0;
                        instr_valid <= 1'b1;
                     end
                  end else if (clear) begin
                     prog_len <= '0;
                     overflow <= 1'b0;
                     state    <= IDLE;
                  end else if (wr_en) begin
                     if (full)
                        overflow <= 1'b1;
                     else
                        prog_len <= prog_len + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule
